// File: rtl/data_port_arbiter_pkg.sv
// Shared definitions for the data-side port arbiter: full-line type code,
// read/write FSM encodings and the owner constants used by both arbiters.
package data_port_arbiter_pkg;

    // Bridge type code for a full cache-line transfer
    localparam logic [2:0] LINE_TYPE = 3'b100;

    // Owner encoding; OWNER_UNC is the reset value of the round-robin
    // state, so the dcache wins the first tie after reset.
    localparam logic OWNER_UNC   = 1'b0;
    localparam logic OWNER_CACHE = 1'b1;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_REQ  = 2'd1,
        R_RESP = 2'd2
    } rd_state_t;

    typedef enum logic {
        W_IDLE = 1'b0,
        W_REQ  = 1'b1
    } wr_state_t;

endpackage

// File: rtl/data_port_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin picker (dcache vs uncached) with a single
// state bit remembering the last winner. A tie goes to the side that did
// not win last; the state only moves when a grant is actually issued.
module rr_arb2
    import data_port_arbiter_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic req_c,
    input  logic req_u,
    output logic gnt_c,
    output logic gnt_u
);

    logic last;

    // Combinational pick, only while the owning FSM can take a request
    always_comb begin
        gnt_c = en && req_c && (!req_u || (last == OWNER_UNC));
        gnt_u = en && req_u && (!req_c || (last == OWNER_CACHE));
    end

    // Remember the most recent winner
    always_ff @(posedge clk) begin
        if (reset) begin
            last <= OWNER_UNC;
        end else if (gnt_c) begin
            last <= OWNER_CACHE;
        end else if (gnt_u) begin
            last <= OWNER_UNC;
        end
    end

endmodule

// File: rtl/data_port_arbiter.sv
// data_port_arbiter: shares the bridge data port between the dcache and the
// uncached load/store unit. Reads: one outstanding at a time, return beats
// routed to the owner with zero latency. Writes: separately arbitrated, one
// write per bridge handshake. Uncached reads wait for all writes to drain.
// Optional macro DATA_ARB_PERF_EN adds 32-bit grant and stall counters.
module data_port_arbiter
    import data_port_arbiter_pkg::*;
#(
    parameter int         LINE_WIDTH = 256,
    parameter logic [2:0] LINE_TYPE  = data_port_arbiter_pkg::LINE_TYPE
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  c_rd_req,
    input  logic [31:0]           c_rd_addr,
    output logic                  c_rd_rdy,
    output logic                  c_ret_valid,
    output logic                  c_ret_last,
    output logic [31:0]           c_ret_data,
    input  logic                  c_wr_req,
    input  logic [31:0]           c_wr_addr,
    input  logic [LINE_WIDTH-1:0] c_wr_data,
    output logic                  c_wr_rdy,
    input  logic                  u_rd_req,
    input  logic [2:0]            u_rd_type,
    input  logic [31:0]           u_rd_addr,
    output logic                  u_rd_rdy,
    output logic                  u_ret_valid,
    output logic [31:0]           u_ret_data,
    input  logic                  u_wr_req,
    input  logic [2:0]            u_wr_type,
    input  logic [31:0]           u_wr_addr,
    input  logic [3:0]            u_wr_wstrb,
    input  logic [31:0]           u_wr_data,
    output logic                  u_wr_rdy,
    output logic                  data_rd_req,
    output logic [2:0]            data_rd_type,
    output logic [31:0]           data_rd_addr,
    input  logic                  data_rd_rdy,
    input  logic                  data_ret_valid,
    input  logic                  data_ret_last,
    input  logic [31:0]           data_ret_data,
    output logic                  data_wr_req,
    output logic [2:0]            data_wr_type,
    output logic [31:0]           data_wr_addr,
    output logic [3:0]            data_wr_wstrb,
    output logic [LINE_WIDTH-1:0] data_wr_data,
    input  logic                  data_wr_rdy,
    input  logic                  write_buffer_empty
`ifdef DATA_ARB_PERF_EN
    ,
    output logic [31:0]           perf_c_rd_cnt,
    output logic [31:0]           perf_u_rd_cnt,
    output logic [31:0]           perf_wr_cnt,
    output logic [31:0]           perf_u_stall_cnt
`endif
);

    rd_state_t rd_state, rd_next;
    wr_state_t wr_state, wr_next;

    logic                  rd_owner;
    logic [2:0]            rd_type_q;
    logic [31:0]           rd_addr_q;
    logic [2:0]            wr_type_q;
    logic [31:0]           wr_addr_q;
    logic [3:0]            wr_wstrb_q;
    logic [LINE_WIDTH-1:0] wr_data_q;

    logic wr_idle, wr_accept, u_rd_order_ok;
    logic rd_gnt_c, rd_gnt_u, wr_gnt_c, wr_gnt_u;

    // An uncached read may only go out when no write is pending anywhere:
    // write FSM idle, nothing being accepted now, bridge buffer drained.
    assign wr_idle       = (wr_state == W_IDLE);
    assign wr_accept     = wr_idle && (c_wr_req || u_wr_req);
    assign u_rd_order_ok = wr_idle && !wr_accept && write_buffer_empty;

    rr_arb2 u_rd_arb (
        .clk   (clk),
        .reset (reset),
        .en    (rd_state == R_IDLE),
        .req_c (c_rd_req),
        .req_u (u_rd_req && u_rd_order_ok),
        .gnt_c (rd_gnt_c),
        .gnt_u (rd_gnt_u)
    );

    rr_arb2 u_wr_arb (
        .clk   (clk),
        .reset (reset),
        .en    (wr_idle),
        .req_c (c_wr_req),
        .req_u (u_wr_req),
        .gnt_c (wr_gnt_c),
        .gnt_u (wr_gnt_u)
    );

    assign data_rd_type  = rd_type_q;
    assign data_rd_addr  = rd_addr_q;
    assign data_wr_type  = wr_type_q;
    assign data_wr_addr  = wr_addr_q;
    assign data_wr_wstrb = wr_wstrb_q;
    assign data_wr_data  = wr_data_q;

    // Read FSM next state, accept strobes and owner-steered return path
    always_comb begin
        rd_next     = rd_state;
        c_rd_rdy    = 1'b0;
        u_rd_rdy    = 1'b0;
        data_rd_req = 1'b0;
        c_ret_valid = 1'b0;
        c_ret_last  = 1'b0;
        c_ret_data  = 32'd0;
        u_ret_valid = 1'b0;
        u_ret_data  = 32'd0;
        case (rd_state)
            R_IDLE: begin
                c_rd_rdy = rd_gnt_c;
                u_rd_rdy = rd_gnt_u;
                if (rd_gnt_c || rd_gnt_u) rd_next = R_REQ;
            end
            R_REQ: begin
                data_rd_req = 1'b1;
                if (data_rd_rdy) rd_next = R_RESP;
            end
            R_RESP: begin
                if (rd_owner == OWNER_CACHE) begin
                    c_ret_valid = data_ret_valid;
                    c_ret_last  = data_ret_valid && data_ret_last;
                    c_ret_data  = data_ret_data;
                end else begin
                    u_ret_valid = data_ret_valid;
                    u_ret_data  = data_ret_data;
                end
                if (data_ret_valid && data_ret_last) rd_next = R_IDLE;
            end
            default: rd_next = R_IDLE;
        endcase
    end

    // Read FSM state and the request latched at grant time
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_state  <= R_IDLE;
            rd_owner  <= OWNER_UNC;
            rd_type_q <= 3'd0;
            rd_addr_q <= 32'd0;
        end else begin
            rd_state <= rd_next;
            if (rd_gnt_c) begin
                rd_owner  <= OWNER_CACHE;
                rd_type_q <= LINE_TYPE;
                rd_addr_q <= c_rd_addr;
            end else if (rd_gnt_u) begin
                rd_owner  <= OWNER_UNC;
                rd_type_q <= u_rd_type;
                rd_addr_q <= u_rd_addr;
            end
        end
    end

    // Write FSM next state and accept strobes
    always_comb begin
        wr_next     = wr_state;
        c_wr_rdy    = 1'b0;
        u_wr_rdy    = 1'b0;
        data_wr_req = 1'b0;
        case (wr_state)
            W_IDLE: begin
                c_wr_rdy = wr_gnt_c;
                u_wr_rdy = wr_gnt_u;
                if (wr_gnt_c || wr_gnt_u) wr_next = W_REQ;
            end
            W_REQ: begin
                data_wr_req = 1'b1;
                if (data_wr_rdy) wr_next = W_IDLE;
            end
            default: wr_next = W_IDLE;
        endcase
    end

    // Write FSM state and the write latched at grant time
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_state   <= W_IDLE;
            wr_type_q  <= 3'd0;
            wr_addr_q  <= 32'd0;
            wr_wstrb_q <= 4'd0;
            wr_data_q  <= '0;
        end else begin
            wr_state <= wr_next;
            if (wr_gnt_c) begin
                wr_type_q  <= LINE_TYPE;
                wr_addr_q  <= c_wr_addr;
                wr_wstrb_q <= 4'hf;
                wr_data_q  <= c_wr_data;
            end else if (wr_gnt_u) begin
                wr_type_q  <= u_wr_type;
                wr_addr_q  <= u_wr_addr;
                wr_wstrb_q <= u_wr_wstrb;
                wr_data_q  <= {{(LINE_WIDTH-32){1'b0}}, u_wr_data};
            end
        end
    end

`ifdef DATA_ARB_PERF_EN
    logic u_rd_stall;
    assign u_rd_stall = u_rd_req && (rd_state == R_IDLE) && !u_rd_order_ok;

    // Free-running grant and ordering-stall counters, wrapping at 2^32
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_c_rd_cnt    <= 32'd0;
            perf_u_rd_cnt    <= 32'd0;
            perf_wr_cnt      <= 32'd0;
            perf_u_stall_cnt <= 32'd0;
        end else begin
            if (rd_gnt_c)             perf_c_rd_cnt    <= perf_c_rd_cnt + 32'd1;
            if (rd_gnt_u)             perf_u_rd_cnt    <= perf_u_rd_cnt + 32'd1;
            if (wr_gnt_c || wr_gnt_u) perf_wr_cnt      <= perf_wr_cnt + 32'd1;
            if (u_rd_stall)           perf_u_stall_cnt <= perf_u_stall_cnt + 32'd1;
        end
    end
`endif

endmodule
